// File: rtl/uop_pkg.sv
// Micro-op opcode definitions shared by the issue queue and the ALU.
package uop_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8
  } op_t;

endpackage

// File: rtl/uop_issue_queue.sv
// uop_issue_queue: circular FIFO of decoded micro-ops feeding the ALU.
// The oldest entry is presented with a valid/ready handshake.
// A synchronous flush (or reset) empties the queue in one edge.
// Optional feature: define UOP_ISSUE_BYPASS_EN to let a micro-op fall
// through combinationally when the queue is empty.
module uop_issue_queue
  import uop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  op_t                        in_op,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  input  logic [$clog2(W)-1:0]       in_shamt,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output op_t                        out_op,
  output logic [W-1:0]               out_a,
  output logic [W-1:0]               out_b,
  output logic [$clog2(W)-1:0]       out_shamt,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(W);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    op_t              op;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [SW-1:0]    shamt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  entry_t in_entry;
  entry_t head;
  logic   empty;
  logic   full;
  logic   push;
  logic   pop;
  logic   wr_en;
  logic   rd_en;

  // Handshake decode: what is accepted, what is presented, and whether
  // storage is actually written/read this cycle.
  always_comb begin
    in_entry = '{op: in_op, a: in_a, b: in_b, shamt: in_shamt, tag: in_tag};
    empty    = (count == '0);
    full     = (count == FULL_COUNT);
    in_ready = !rst && !flush && !full;
    push     = in_valid && in_ready;
    head     = mem[rd_ptr];
`ifdef UOP_ISSUE_BYPASS_EN
    // An empty queue shows the incoming micro-op directly; if the ALU takes
    // it in the same cycle it never touches storage.
    if (empty) begin
      head      = in_entry;
      out_valid = push;
    end else begin
      out_valid = 1'b1;
    end
    pop   = out_valid && out_ready;
    wr_en = push && !(empty && out_ready);
    rd_en = pop && !empty;
`else
    out_valid = !empty;
    pop       = out_valid && out_ready;
    wr_en     = push;
    rd_en     = pop;
`endif
  end

  // Head fields are forced to a NOP bubble whenever nothing is presented.
  always_comb begin
    out_op    = OP_NOP;
    out_a     = '0;
    out_b     = '0;
    out_shamt = '0;
    out_tag   = '0;
    if (out_valid) begin
      out_op    = head.op;
      out_a     = head.a;
      out_b     = head.b;
      out_shamt = head.shamt;
      out_tag   = head.tag;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue and win
  // over any handshake in the same cycle. Pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uop_issue_queue.sv
// Testbench for uop_issue_queue: directed vector table, hand-written
// bypass/latency sequence and a scoreboarded random back-pressure run.
module tb_uop_issue_queue;
  import uop_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 64;
  localparam int TAG_W = 4;
`ifdef UOP_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  op_t         in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [5:0]  in_shamt;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  op_t         out_op;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [5:0]  out_shamt;
  logic [3:0]  out_tag;
  logic [2:0]  count;

  int total_checks;
  int passed_checks;

  uop_issue_queue #(.DEPTH(DEPTH), .W(W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt), .out_tag(out_tag),
    .count(count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    op_t         op;
    logic [63:0] a;
    logic [3:0]  tag;
    logic        out_ready;
    logic        e_in_ready;
    logic        e_out_valid;
    op_t         e_op;
    logic [63:0] e_a;
    logic [3:0]  e_tag;
    logic [2:0]  e_count;
  } vec_t;

  typedef struct {
    op_t         op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  shamt;
    logic [3:0]  tag;
  } uop_t;

  vec_t vecs[$];
  uop_t model_q[$];

  function automatic vec_t mk(logic r, logic f, logic iv, op_t op, logic [63:0] a,
                              logic [3:0] tag, logic ordy, logic e_ir, logic e_ov,
                              op_t e_op, logic [63:0] e_a, logic [3:0] e_tag,
                              logic [2:0] e_cnt);
    vec_t v;
    v.rst = r; v.flush = f; v.in_valid = iv; v.op = op; v.a = a; v.tag = tag;
    v.out_ready = ordy; v.e_in_ready = e_ir; v.e_out_valid = e_ov;
    v.e_op = e_op; v.e_a = e_a; v.e_tag = e_tag; v.e_count = e_cnt;
    return v;
  endfunction

  task automatic apply_stimulus(input logic r, input logic f, input logic iv, input op_t op,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [5:0] sh, input logic [3:0] tag,
                                input logic ordy);
    rst = r; flush = f; in_valid = iv; in_op = op;
    in_a = a; in_b = b; in_shamt = sh; in_tag = tag; out_ready = ordy;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  initial begin
    op_t         byp_op;
    logic [63:0] byp_a;
    logic [3:0]  byp_tag;
    int          sent;
    int          cycles;
    bit          exp_ir;
    bit          exp_ov;
    uop_t        exp_head;
    uop_t        cur;

    total_checks  = 0;
    passed_checks = 0;
    apply_stimulus(1'b1, 1'b0, 1'b1, OP_ADD, 64'd0, 64'd1, 6'd0, 4'd0, 1'b0);

    // rst flush iv op a tag ordy | in_ready out_valid op a tag count
    byp_op = BYP ? OP_ADD : OP_NOP;
    vecs.push_back(mk(1, 0, 1, OP_ADD, 64'd0,   4'd0,  0, 0, 0, OP_NOP, 64'd0, 4'd0, 3'd0));
    vecs.push_back(mk(1, 0, 1, OP_ADD, 64'd0,   4'd0,  0, 0, 0, OP_NOP, 64'd0, 4'd0, 3'd0));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd0,   4'd0,  0, 1, BYP, byp_op, 64'd0, 4'd0, 3'd0));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd16,  4'd1,  0, 1, 1, OP_ADD, 64'd0, 4'd0, 3'd1));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd32,  4'd2,  0, 1, 1, OP_ADD, 64'd0, 4'd0, 3'd2));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd48,  4'd3,  0, 1, 1, OP_ADD, 64'd0, 4'd0, 3'd3));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd64,  4'd4,  0, 0, 1, OP_ADD, 64'd0, 4'd0, 3'd4));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd64,  4'd4,  1, 0, 1, OP_ADD, 64'd0, 4'd0, 3'd4));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd64,  4'd4,  1, 1, 1, OP_ADD, 64'd16, 4'd1, 3'd3));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd80,  4'd5,  1, 1, 1, OP_ADD, 64'd32, 4'd2, 3'd3));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd96,  4'd6,  1, 1, 1, OP_ADD, 64'd48, 4'd3, 3'd3));
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd112, 4'd7,  1, 1, 1, OP_ADD, 64'd64, 4'd4, 3'd3));
    vecs.push_back(mk(0, 0, 0, OP_NOP, 64'd0,   4'd0,  1, 1, 1, OP_ADD, 64'd80, 4'd5, 3'd3));
    vecs.push_back(mk(0, 0, 0, OP_NOP, 64'd0,   4'd0,  1, 1, 1, OP_ADD, 64'd96, 4'd6, 3'd2));
    vecs.push_back(mk(0, 0, 0, OP_NOP, 64'd0,   4'd0,  1, 1, 1, OP_ADD, 64'd112, 4'd7, 3'd1));
    vecs.push_back(mk(0, 0, 0, OP_NOP, 64'd0,   4'd0,  1, 1, 0, OP_NOP, 64'd0, 4'd0, 3'd0));
    byp_op = BYP ? OP_SUB : OP_NOP;
    byp_a  = BYP ? 64'd128 : 64'd0;
    byp_tag = BYP ? 4'd8 : 4'd0;
    vecs.push_back(mk(0, 0, 1, OP_SUB, 64'd128, 4'd8,  0, 1, BYP, byp_op, byp_a, byp_tag, 3'd0));
    vecs.push_back(mk(0, 0, 1, OP_SUB, 64'd144, 4'd9,  0, 1, 1, OP_SUB, 64'd128, 4'd8, 3'd1));
    vecs.push_back(mk(0, 0, 1, OP_SUB, 64'd160, 4'd10, 0, 1, 1, OP_SUB, 64'd128, 4'd8, 3'd2));
    vecs.push_back(mk(0, 1, 1, OP_SUB, 64'd176, 4'd11, 1, 0, 1, OP_SUB, 64'd128, 4'd8, 3'd3));
    vecs.push_back(mk(0, 0, 0, OP_NOP, 64'd0,   4'd0,  1, 1, 0, OP_NOP, 64'd0, 4'd0, 3'd0));
    byp_op = BYP ? OP_ADD : OP_NOP;
    byp_a  = BYP ? 64'd192 : 64'd0;
    byp_tag = BYP ? 4'd12 : 4'd0;
    vecs.push_back(mk(0, 0, 1, OP_ADD, 64'd192, 4'd12, 0, 1, BYP, byp_op, byp_a, byp_tag, 3'd0));
    vecs.push_back(mk(1, 0, 1, OP_ADD, 64'd208, 4'd13, 0, 0, 1, OP_ADD, 64'd192, 4'd12, 3'd1));
    vecs.push_back(mk(0, 0, 0, OP_NOP, 64'd0,   4'd0,  0, 1, 0, OP_NOP, 64'd0, 4'd0, 3'd0));

    // Directed table: reset, fill, drain with wrap, flush, mid-run reset.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply_stimulus(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].op,
                     vecs[i].a, vecs[i].a + 64'd1, 6'(vecs[i].tag), vecs[i].tag,
                     vecs[i].out_ready);
      @(negedge clk);
      check_output($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_in_ready));
      check_output($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_out_valid));
      check_output($sformatf("v%0d out_op", i), 64'(out_op), 64'(vecs[i].e_op));
      check_output($sformatf("v%0d out_a", i), out_a, vecs[i].e_a);
      check_output($sformatf("v%0d out_b", i), out_b,
                   vecs[i].e_out_valid ? vecs[i].e_a + 64'd1 : 64'd0);
      check_output($sformatf("v%0d out_shamt", i), 64'(out_shamt),
                   vecs[i].e_out_valid ? 64'(vecs[i].e_tag) : 64'd0);
      check_output($sformatf("v%0d out_tag", i), 64'(out_tag), 64'(vecs[i].e_tag));
      check_output($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_count));
    end

    // Push into an empty queue with the ALU ready: zero latency with the
    // fall-through path, one cycle through storage without it.
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b0, 1'b1, OP_SUB, 64'd5, 64'd3, 6'd0, 4'd9, 1'b1);
    @(negedge clk);
    check_output("byp0 out_valid", 64'(out_valid), 64'(BYP));
    check_output("byp0 out_op", 64'(out_op), BYP ? 64'(OP_SUB) : 64'(OP_NOP));
    check_output("byp0 out_a", out_a, BYP ? 64'd5 : 64'd0);
    check_output("byp0 out_b", out_b, BYP ? 64'd3 : 64'd0);
    check_output("byp0 out_tag", 64'(out_tag), BYP ? 64'd9 : 64'd0);
    check_output("byp0 count", 64'(count), 64'd0);
    @(posedge clk); #1;
    apply_stimulus(1'b0, 1'b0, 1'b0, OP_NOP, 64'd0, 64'd0, 6'd0, 4'd0, 1'b1);
    @(negedge clk);
    check_output("byp1 out_valid", 64'(out_valid), BYP ? 64'd0 : 64'd1);
    check_output("byp1 out_op", 64'(out_op), BYP ? 64'(OP_NOP) : 64'(OP_SUB));
    check_output("byp1 out_a", out_a, BYP ? 64'd0 : 64'd5);
    check_output("byp1 out_b", out_b, BYP ? 64'd0 : 64'd3);
    check_output("byp1 out_tag", 64'(out_tag), BYP ? 64'd0 : 64'd9);
    check_output("byp1 count", 64'(count), BYP ? 64'd0 : 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("byp2 out_valid", 64'(out_valid), 64'd0);
    check_output("byp2 count", 64'(count), 64'd0);

    // Random back-pressure against a queue model.
    sent   = 0;
    cycles = 0;
    while ((sent < 1000 || model_q.size() != 0) && cycles < 20000) begin
      @(posedge clk); #1;
      cycles++;
      cur.op    = op_t'($urandom_range(0, 8));
      cur.a     = {$urandom, $urandom};
      cur.b     = {$urandom, $urandom};
      cur.shamt = 6'($urandom_range(0, 63));
      cur.tag   = 4'($urandom_range(0, 15));
      apply_stimulus(1'b0, 1'b0, (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0,
                     cur.op, cur.a, cur.b, cur.shamt, cur.tag,
                     ($urandom_range(0, 3) != 0));
      @(negedge clk);
      exp_ir = (model_q.size() != DEPTH);
      exp_ov = 1'b0;
      exp_head = '{op: OP_NOP, a: 64'd0, b: 64'd0, shamt: 6'd0, tag: 4'd0};
      if (model_q.size() != 0) begin
        exp_ov = 1'b1;
        exp_head = model_q[0];
      end else if (BYP && in_valid) begin
        exp_ov = 1'b1;
        exp_head = cur;
      end
      check_output("rnd in_ready", 64'(in_ready), 64'(exp_ir));
      check_output("rnd out_valid", 64'(out_valid), 64'(exp_ov));
      check_output("rnd count", 64'(count), 64'(model_q.size()));
      check_output("rnd out_op", 64'(out_op), 64'(exp_head.op));
      check_output("rnd out_a", out_a, exp_head.a);
      check_output("rnd out_b", out_b, exp_head.b);
      check_output("rnd out_shamt", 64'(out_shamt), 64'(exp_head.shamt));
      check_output("rnd out_tag", 64'(out_tag), 64'(exp_head.tag));
      if (exp_ov && out_ready && model_q.size() == 0) begin
        sent++;
      end else begin
        if (exp_ov && out_ready) void'(model_q.pop_front());
        if (in_valid && exp_ir) begin
          model_q.push_back(cur);
          sent++;
        end
      end
    end
    total_checks++;
    if (cycles < 20000) passed_checks++;
    else $display("[TB] FAIL rnd timeout: got %0d cycles, expected under 20000", cycles);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
